cipu_stream: RTL and testbench
==============================

Name: cipu_stream

Overview:
- Parametrised successor to the fixed 16-entry check-in unit. It buffers passenger IDs in a queue and baggage items in a stack.
- It serves ';'-delimited baggage pop requests during intake. After '$' it drains passengers in arrival order, then drains the remaining baggage bottom-up.
- New over the previous generation: configurable depth and pop width, valid/ready backpressure on every output, an input-ready signal, sticky overflow/underflow error flags, and restart without reset.

Parameters:
- DEPTH, 16: entries in each of the passenger queue and the baggage stack (power of 2, >= 2).
- NUM_W, 4: width of thing_num.
- SEP_CODE, 8'h3B: pop-request delimiter (';').
- END_CODE, 8'h24: end-of-input code ('$').
- ZERO_CODE, 8'h30: emitted for a pop request of 0 items ('0').

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begins a session from IDLE or FINISH.
- people_in  in  8  passenger byte.
- people_vld  in  1  people_in is valid.
- thing_in  in  8  baggage byte or delimiter.
- thing_vld  in  1  thing_in is valid.
- thing_num  in  NUM_W  pop count, sampled with SEP_CODE.
- thing_ready  out  1  thing_in is accepted this cycle.
- out_ready  in  1  downstream accepts the current output beat.
- people_out  out  8  passenger output.
- valid_fifo  out  1  people_out valid.
- thing_out  out  8  baggage output.
- valid_lifo  out  1  thing_out valid (pop response).
- valid_fifo2  out  1  thing_out valid (final drain).
- done_thing  out  1  one-cycle pulse: a pop request has completed.
- done_lifo  out  1  one-cycle pulse: END_CODE accepted.
- done_fifo  out  1  one-cycle pulse: passenger drain complete.
- done_fifo2  out  1  one-cycle pulse: baggage drain complete.
- ovf  out  1  sticky: a push was attempted while full.
- udf  out  1  sticky: pop count exceeded stack occupancy.

Behaviour:
- Reset: every output 0; all pointers and counters 0; state IDLE. Asserting rst mid-session aborts immediately; stored data is discarded.
- States: IDLE, READ, POP, FIFO_OUT, LIFO_OUT, FINISH.
- IDLE / FINISH with start=1: clear pointers, ovf and udf; go to READ next cycle. FINISH with start=0: hold, all valids 0.
- READ, passenger path:
  - Push when people_vld=1 and people_in is in 'A'..'Z'; other bytes are ignored.
  - Push while queue full: byte dropped, ovf set.
- thing_ready = 1 in READ, 0 in every other state.
- READ, baggage path (when thing_vld=1):
  - Ordinary byte: pushed onto the stack. Push while stack full: byte dropped, ovf set.
  - SEP_CODE: latch cnt = min(thing_num, occupancy); set udf if thing_num > occupancy; go to POP.
  - END_CODE: done_lifo pulses next cycle; go to FIFO_OUT.
- Passenger pushes continue in the same cycle as a delimiter and while in POP.
- POP:
  - If the latched thing_num = 0: one beat of ZERO_CODE.
  - Otherwise: cnt beats, popping from the top of the stack.
  - First valid_lifo is asserted the cycle after SEP_CODE is accepted.
  - A beat completes when valid_lifo and out_ready are both 1. The next beat is presented on the following cycle; there are no bubbles while out_ready stays 1.
  - The cycle after the last beat completes: valid_lifo=0, done_thing pulses, return to READ.
  - thing_num > 0 with an empty stack: zero beats; done_thing pulses the cycle after SEP_CODE; udf set.
- FIFO_OUT:
  - Present passengers in arrival order on people_out with valid_fifo, same handshake as POP.
  - When the queue is empty: valid_fifo=0, done_fifo pulses, go to LIFO_OUT.
  - An empty queue gives done_fifo on the first FIFO_OUT cycle.
- LIFO_OUT:
  - Present remaining stack entries from index 0 (oldest) upward on thing_out with valid_fifo2.
  - Then done_fifo2 pulses; go to FINISH.
- Hold rule: while a valid is 1 and out_ready is 0, the data and valid hold stable.
- Pointers are log2(DEPTH)+1 bits wide, so full and empty are distinct. Occupancy never exceeds DEPTH.

Decomposition:
- Shared package cipu_pkg holds:
  - state enum (IDLE, READ, POP, FIFO_OUT, LIFO_OUT, FINISH);
  - default codes SEP/END/ZERO;
  - letter-range constants 'A', 'Z'.
- One sub-module, cipu_buf: DEPTH x 8 storage with push, pop_top, read_bottom_advance, full, empty and count outputs. Instantiated twice: the passenger queue uses push/read_bottom; the baggage stack uses push/pop_top/read_bottom.

Test Plan:
- Intake "AB" / things "x,y,z", SEP with num=2, then END; out_ready=1:
  - valid_lifo beats 'z','y', then done_thing;
  - passengers 'A','B', then done_fifo;
  - drain 'x', then done_fifo2.
- SEP with num=0 → one ZERO_CODE beat ('0'), then done_thing; stack unchanged.
- SEP with num=3 on a 1-entry stack → one beat, udf=1; later drain is empty, giving done_fifo2 immediately.
- Push DEPTH+1 things → ovf=1; final drain yields exactly DEPTH items, oldest first.
- out_ready held low 5 cycles mid-drain → people_out and valid_fifo stable throughout; no item lost or duplicated.
- rst asserted in LIFO_OUT → all outputs 0 asynchronously.
- FINISH then start → second session starts with empty buffers and ovf/udf cleared.

Source files
------------

// File: rtl/cipu_pkg.sv
// cipu_pkg: shared state encoding and byte codes for the check-in stream unit
package cipu_pkg;
  typedef enum logic [2:0] {IDLE, READ, POP, FIFO_OUT, LIFO_OUT, FINISH} state_t;
  localparam logic [7:0] SEP_DEF  = 8'h3B;
  localparam logic [7:0] END_DEF  = 8'h24;
  localparam logic [7:0] ZERO_DEF = 8'h30;
  localparam logic [7:0] LET_A    = 8'h41;
  localparam logic [7:0] LET_Z    = 8'h5A;
endpackage

// File: rtl/cipu_buf.sv
// cipu_buf: DEPTH x 8 buffer usable as a queue (push/read_bottom) or a stack (push/pop_top/read_bottom)
module cipu_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop_top,
  input  logic                     read_bottom,
  input  logic                     from_top,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] tp, bp, tp_dec;
  assign tp_dec = tp - 1'b1;
  always_ff @(posedge clk)
    if (push) mem[tp[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tp <= '0;
      bp <= '0;
    end else if (clr) begin
      tp <= '0;
      bp <= '0;
    end else begin
      tp <= push ? tp + 1'b1 : pop_top ? tp_dec : tp;
      if (read_bottom) bp <= bp + 1'b1;
    end
  assign count = tp - bp;
  assign full  = count == CW'(DEPTH);
  assign empty = tp == bp;
  assign dout  = from_top ? mem[tp_dec[AW-1:0]] : mem[bp[AW-1:0]];
endmodule

// File: rtl/cipu_stream.sv
// cipu_stream: passenger queue + baggage stack with pop requests, ordered drains and valid/ready outputs
module cipu_stream
  import cipu_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         NUM_W     = 4,
  parameter logic [7:0] SEP_CODE  = SEP_DEF,
  parameter logic [7:0] END_CODE  = END_DEF,
  parameter logic [7:0] ZERO_CODE = ZERO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       people_in,
  input  logic             people_vld,
  input  logic [7:0]       thing_in,
  input  logic             thing_vld,
  input  logic [NUM_W-1:0] thing_num,
  output logic             thing_ready,
  input  logic             out_ready,
  output logic [7:0]       people_out,
  output logic             valid_fifo,
  output logic [7:0]       thing_out,
  output logic             valid_lifo,
  output logic             valid_fifo2,
  output logic             done_thing,
  output logic             done_lifo,
  output logic             done_fifo,
  output logic             done_fifo2,
  output logic             ovf,
  output logic             udf
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t          state, nxt;
  logic [CW-1:0]   cnt, s_count, unused_q_count;
  logic            zero, clr, q_push, q_rd, s_push, s_pop, s_rd, q_full, q_empty, s_full, s_empty;
  logic            is_sep, is_end, is_item, pax_try, gt;
  logic [7:0]      q_dout, s_dout;
  cipu_buf #(.DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .clr(clr), .push(q_push), .din(people_in), .pop_top(1'b0),
    .read_bottom(q_rd), .from_top(1'b0), .dout(q_dout), .full(q_full), .empty(q_empty),
    .count(unused_q_count)
  );
  cipu_buf #(.DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst(rst), .clr(clr), .push(s_push), .din(thing_in), .pop_top(s_pop),
    .read_bottom(s_rd), .from_top(state == POP), .dout(s_dout), .full(s_full), .empty(s_empty),
    .count(s_count)
  );
  assign is_sep  = state == READ && thing_vld && thing_in == SEP_CODE;
  assign is_end  = state == READ && thing_vld && thing_in == END_CODE;
  assign is_item = state == READ && thing_vld && thing_in != SEP_CODE && thing_in != END_CODE;
  assign pax_try = (state == READ || state == POP) && people_vld && people_in >= LET_A && people_in <= LET_Z;
  assign q_push  = pax_try && !q_full;
  assign s_push  = is_item && !s_full;
  assign gt      = {{CW{1'b0}}, thing_num} > {{NUM_W{1'b0}}, s_count};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt         = state;
    clr         = 1'b0;
    thing_ready = 1'b0;
    valid_fifo  = 1'b0;
    valid_lifo  = 1'b0;
    valid_fifo2 = 1'b0;
    done_thing  = 1'b0;
    done_fifo   = 1'b0;
    done_fifo2  = 1'b0;
    people_out  = '0;
    thing_out   = '0;
    s_pop       = 1'b0;
    s_rd        = 1'b0;
    q_rd        = 1'b0;
    case (state)
      IDLE, FINISH: begin
        clr = start;
        nxt = start ? READ : state;
      end
      READ: begin
        thing_ready = 1'b1;
        nxt = is_sep ? POP : is_end ? FIFO_OUT : READ;
      end
      POP: begin
        done_thing = cnt == '0;
        valid_lifo = cnt != '0;
        thing_out  = valid_lifo ? (zero ? ZERO_CODE : s_dout) : 8'h00;
        s_pop      = valid_lifo && out_ready && !zero;
        nxt        = done_thing ? READ : POP;
      end
      FIFO_OUT: begin
        done_fifo  = q_empty;
        valid_fifo = !q_empty;
        people_out = valid_fifo ? q_dout : 8'h00;
        q_rd       = valid_fifo && out_ready;
        nxt        = q_empty ? LIFO_OUT : FIFO_OUT;
      end
      LIFO_OUT: begin
        done_fifo2  = s_empty;
        valid_fifo2 = !s_empty;
        thing_out   = valid_fifo2 ? s_dout : 8'h00;
        s_rd        = valid_fifo2 && out_ready;
        nxt         = s_empty ? FINISH : LIFO_OUT;
      end
      default: nxt = IDLE;
    endcase
  end
  // a zero-count request is one ZERO_CODE beat, so it is tracked as cnt=1 with zero set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      done_lifo <= 1'b0;
    end else begin
      done_lifo <= is_end;
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if ((pax_try && q_full) || (is_item && s_full)) ovf <= 1'b1;
        if (is_sep && gt) udf <= 1'b1;
      end
      if (is_sep) begin
        zero <= thing_num == '0;
        cnt  <= thing_num == '0 ? CW'(1) : gt ? s_count : CW'(thing_num);
      end else if (valid_lifo && out_ready) cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_cipu_stream.sv
// tb_cipu_stream: directed vector table plus hand-written multi-cycle sequences for cipu_stream
module tb_cipu_stream;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, people_vld = 1'b0, thing_vld = 1'b0, out_ready = 1'b0;
  logic [7:0] people_in = '0, thing_in = '0;
  logic [3:0] thing_num = '0;
  logic [7:0] people_out, thing_out;
  logic       thing_ready, valid_fifo, valid_lifo, valid_fifo2;
  logic       done_thing, done_lifo, done_fifo, done_fifo2, ovf, udf;
  int         total = 0, bad = 0;

  localparam logic [7:0] SEP = 8'h3B, ENDC = 8'h24;

  cipu_stream dut (
    .clk(clk), .rst(rst), .start(start), .people_in(people_in), .people_vld(people_vld),
    .thing_in(thing_in), .thing_vld(thing_vld), .thing_num(thing_num), .thing_ready(thing_ready),
    .out_ready(out_ready), .people_out(people_out), .valid_fifo(valid_fifo), .thing_out(thing_out),
    .valid_lifo(valid_lifo), .valid_fifo2(valid_fifo2), .done_thing(done_thing), .done_lifo(done_lifo),
    .done_fifo(done_fifo), .done_fifo2(done_fifo2), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       pv;
    logic [7:0] pin;
    logic       tv;
    logic [7:0] tin;
    logic [3:0] num;
    logic       rdy;
    logic [25:0] exp;
  } row_t;
  row_t tbl [18];

  function automatic logic [25:0] mk(input logic tr, vf, vl, vf2, dt, dl, df, df2, ov, ud,
                                     input logic [7:0] po, to);
    return {tr, vf, vl, vf2, dt, dl, df, df2, ov, ud, po, to};
  endfunction

  function automatic logic [25:0] outs();
    return {thing_ready, valid_fifo, valid_lifo, valid_fifo2, done_thing, done_lifo,
            done_fifo, done_fifo2, ovf, udf, people_out, thing_out};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic pv, input logic [7:0] pin, input logic tv,
                      input logic [7:0] tin, input logic [3:0] num, input logic rdy);
    @(negedge clk);
    start = st; people_vld = pv; people_in = pin; thing_vld = tv; thing_in = tin;
    thing_num = num; out_ready = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, rdy);
  endtask

  initial begin
    int  k;
    logic fin;
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[1]  = '{1'b0, 1'b1, "A",   1'b1, "x",   4'd0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[2]  = '{1'b0, 1'b1, "B",   1'b1, "y",   4'd0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[3]  = '{1'b0, 1'b1, "a",   1'b1, "z",   4'd0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, SEP,   4'd2, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,1,0,0,0,0,0,0,0,8'h00,"z")};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,1,0,0,0,0,0,0,0,8'h00,"y")};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,0,1,0,0,0,0,0,8'h00,8'h00)};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, SEP,   4'd0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,1,0,0,0,0,0,0,0,8'h00,"0")};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,0,1,0,0,0,0,0,8'h00,8'h00)};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, ENDC,  4'd0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,1,0,0,0,1,0,0,0,0,"A",8'h00)};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,1,0,0,0,0,0,0,0,0,"B",8'h00)};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,0,0,0,1,0,0,0,8'h00,8'h00)};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,1,0,0,0,0,0,0,8'h00,"x")};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,0,0,0,0,1,0,0,8'h00,8'h00)};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,8'h00,8'h00)};

    #3 chk("in_reset", outs(), 26'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].st, tbl[i].pv, tbl[i].pin, tbl[i].tv, tbl[i].tin, tbl[i].num, tbl[i].rdy);
      chk($sformatf("row%0d", i), outs(), tbl[i].exp);
    end

    // underflow: 3 requested from a 1-entry stack, then both drains are empty
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "k", 4'd0, 1'b1);
    chk("udf_read", outs(), mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00));
    step(1'b0, 1'b0, 8'h00, 1'b1, SEP, 4'd3, 1'b1);
    idle(1'b1);
    chk("udf_beat", outs(), mk(0,0,1,0,0,0,0,0,0,1,8'h00,"k"));
    idle(1'b1);
    chk("udf_done", outs(), mk(0,0,0,0,1,0,0,0,0,1,8'h00,8'h00));
    step(1'b0, 1'b0, 8'h00, 1'b1, ENDC, 4'd0, 1'b1);
    idle(1'b1);
    chk("empty_fifo", outs(), mk(0,0,0,0,0,1,1,0,0,1,8'h00,8'h00));
    idle(1'b1);
    chk("empty_lifo", outs(), mk(0,0,0,0,0,0,0,1,0,1,8'h00,8'h00));

    // overflow with DEPTH+1 pushes, plus output backpressure on the passenger drain
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, i < 3, 8'h43 + 8'(i), 1'b1, 8'h61 + 8'(i), 4'd0, 1'b1);
      if (i == 0) chk("start_clr", {ovf, udf}, 2'b00);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, ENDC, 4'd0, 1'b0);
    chk("ovf_set", outs(), mk(1,0,0,0,0,0,0,0,1,0,8'h00,8'h00));
    idle(1'b0);
    chk("hold_first", outs(), mk(0,1,0,0,0,1,0,0,1,0,"C",8'h00));
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("hold", outs(), mk(0,1,0,0,0,0,0,0,1,0,"C",8'h00));
    end
    k = 0; fin = 1'b0;
    for (int n = 0; n < 10 && !fin; n++) begin
      idle(1'b1);
      if (valid_fifo) begin
        chk("pax_order", people_out, 8'h43 + 8'(k));
        k++;
      end
      if (done_fifo) fin = 1'b1;
    end
    chk("pax_done", fin, 1'b1);
    chk("pax_cnt", k, 3);
    k = 0; fin = 1'b0;
    for (int n = 0; n < 40 && !fin; n++) begin
      idle(1'b1);
      if (valid_fifo2) begin
        chk("bag_order", thing_out, 8'h61 + 8'(k));
        k++;
      end
      if (done_fifo2) fin = 1'b1;
    end
    chk("bag_done", fin, 1'b1);
    chk("bag_cnt", k, 16);

    // restart from FINISH clears flags and buffers
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, ENDC, 4'd0, 1'b1);
    chk("restart_clr", outs(), mk(1,0,0,0,0,0,0,0,0,0,8'h00,8'h00));
    idle(1'b1);
    chk("restart_fifo", outs(), mk(0,0,0,0,0,1,1,0,0,0,8'h00,8'h00));
    idle(1'b1);
    chk("restart_lifo", outs(), mk(0,0,0,0,0,0,0,1,0,0,8'h00,8'h00));

    // asynchronous reset during the baggage drain
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b1);
    step(1'b0, 1'b1, "Q", 1'b1, "q", 4'd0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "r", 4'd0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, ENDC, 4'd0, 1'b1);
    idle(1'b0);
    chk("rst_seq_pax", outs(), mk(0,1,0,0,0,1,0,0,0,0,"Q",8'h00));
    idle(1'b1);
    chk("rst_seq_take", outs(), mk(0,1,0,0,0,0,0,0,0,0,"Q",8'h00));
    idle(1'b1);
    chk("rst_seq_df", outs(), mk(0,0,0,0,0,0,1,0,0,0,8'h00,8'h00));
    idle(1'b0);
    chk("rst_seq_bag", outs(), mk(0,0,0,1,0,0,0,0,0,0,8'h00,"q"));
    #2 rst = 1'b1;
    #1 chk("async_rst", outs(), 26'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    chk("post_rst", outs(), 26'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
